rx_frame_fifo: RTL and testbench
================================

// Module: rx_frame_fifo
// PURPOSE
//  Store-and-forward receive FIFO downstream of the rx MAC path (xgmii2axis + rxpause).
//  Takes the MAC's 64-bit AXIS stream, which has no tready, and buffers whole frames.
//  Frames ending with tuser=1 (bad FCS/error) are discarded; frames that overflow the buffer are discarded.
//  Only complete good frames reach a standard backpressured AXIS master port.
// PARAMETERS
//  ADDR_WIDTH  11  log2 buffer depth in 72+1-bit words; default 2048 words = 16 KB, which holds a 9000 B jumbo frame.
// PORTS
//  clk                 in   1      single clock; all logic is synchronous to its rising edge
//  axis_aresetn        in   1      asynchronous assert, active-low reset
//  s_axis_tdata        in   64     frame data from the rx MAC
//  s_axis_tkeep        in   8      byte enables; only the tlast beat may be partial
//  s_axis_tvalid       in   1      beat valid; no backpressure is possible
//  s_axis_tlast        in   1      last beat of frame
//  s_axis_tuser        in   1      qualified on the tlast beat; 1 = bad frame
//  m_axis_tdata        out  64     buffered frame data
//  m_axis_tkeep        out  8      byte enables
//  m_axis_tvalid       out  1      output beat valid
//  m_axis_tlast        out  1      last beat of frame
//  m_axis_tready       in   1      downstream ready
//  dropped_bad_frames  out  32     count of frames dropped for tuser=1; wraps modulo 2^32
//  dropped_ovf_frames  out  32     count of frames dropped for overflow; wraps modulo 2^32
//  fifo_level          out  ADDR_WIDTH+1  words held, committed plus in-flight; wr_ptr - rd_ptr
// BEHAVIOUR
//  Reset (async assert, sync release): wr_ptr, commit_ptr and rd_ptr = 0; state = ACCEPT.
//   Outputs go to 0 immediately: m_axis_tvalid, m_axis_tlast, tdata, tkeep, both counters, fifo_level.
//   Any partial frame is lost. Upstream shares this reset, so the first beat after release is a frame start.
//  Pointers are ADDR_WIDTH+1 bits. full = (wr_ptr - rd_ptr == 2^ADDR_WIDTH). Read side empty = (rd_ptr == commit_ptr).
//  Write side FSM, evaluated only on cycles with s_axis_tvalid=1:
//   ACCEPT, not full, tlast=0: write the word; wr_ptr+1.
//   ACCEPT, not full, tlast=1, tuser=0: write the word; wr_ptr+1; commit_ptr <= wr_ptr+1.
//   ACCEPT, not full, tlast=1, tuser=1: no write; wr_ptr <= commit_ptr; dropped_bad_frames+1.
//   ACCEPT, full, tlast=0: no write; go to DROP.
//   ACCEPT, full, tlast=1: wr_ptr <= commit_ptr; dropped_ovf_frames+1; stay in ACCEPT.
//   DROP, tlast=0: discard the beat.
//   DROP, tlast=1: wr_ptr <= commit_ptr; dropped_ovf_frames+1 (regardless of tuser); go to ACCEPT.
//  A frame longer than 2^ADDR_WIDTH words is always dropped as overflow; the FIFO never deadlocks.
//  Overflow counts once per frame, never per beat.
//  Rewind releases the dropped frame's words the same cycle; fifo_level reflects this one cycle later.
//  Read side: synchronous RAM read into a 1-deep output register with a prefetch stage.
//   Sustains 1 beat/clk while m_axis_tready=1.
//  AXIS rules: once m_axis_tvalid=1, tvalid/tdata/tkeep/tlast hold stable until a cycle with m_axis_tready=1.
//   tvalid never depends combinationally on tready.
//  Latency: with the output idle, m_axis_tvalid rises exactly 2 clk edges after the edge that samples a
//   good s_axis tlast beat. The first word of a frame is never presented before its commit.
//  Simultaneous commit and read: the read side sees the new commit_ptr one cycle later.
//   A read and a write in the same cycle are both legal, including at full-1.
//  Counters update on the edge following the terminating tlast beat.
// TESTING
//  1. Single good 8-beat frame, last tkeep=0x0F, m_axis_tready=1 -> 8 beats out identical, tvalid 2 edges after tlast, counters 0.
//  2. Good 4-beat, bad 6-beat (tuser=1), good 3-beat back to back -> only 4+3 beats out in order; dropped_bad_frames=1; level returns to 0.
//  3. ADDR_WIDTH=4, m_axis_tready=0, 20-beat frame -> dropped_ovf_frames=1, no output; next 5-beat frame passes intact.
//  4. m_axis_tready toggling 1010... during a 64-beat frame -> no beat lost/duplicated; data stable while tready=0.
//  5. Fill to full-1 with committed frames, then read and write concurrently -> no false overflow; order preserved.
//  6. Assert axis_aresetn mid-frame and mid-output -> m_axis_tvalid=0 at once; after release a new frame passes cleanly.

Source files
------------

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: store-and-forward rx frame buffer; bad-FCS and overflowing frames are rewound away,
// only committed good frames are replayed on a backpressured AXIS master.
module rx_frame_fifo #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  axis_aresetn,
  input  logic [63:0]           s_axis_tdata,
  input  logic [7:0]            s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [31:0]           dropped_bad_frames,
  output logic [31:0]           dropped_ovf_frames,
  output logic [ADDR_WIDTH:0]   fifo_level
);
  typedef enum logic {ACCEPT, DROP} state_t;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, level_q, used;
  logic [31:0] bad_q, bad_d, ovf_q, ovf_d;
  logic [72:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [72:0] ram_q, out_q;
  logic ram_vld_q, out_vld_q, full, empty, wr_en, rd_en, out_rdy;
  assign used  = wr_ptr_q - rd_ptr_q;
  assign full  = used == FULL_LVL;
  assign empty = rd_ptr_q == commit_ptr_q;
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    bad_d        = bad_q;
    ovf_d        = ovf_q;
    wr_en        = 1'b0;
    if (s_axis_tvalid) begin
      if (state_q == DROP || full) begin
        state_d = s_axis_tlast ? ACCEPT : DROP;
        if (s_axis_tlast) begin
          wr_ptr_d = commit_ptr_q;
          ovf_d    = ovf_q + 32'd1;
        end
      end else if (s_axis_tlast && s_axis_tuser) begin
        wr_ptr_d = commit_ptr_q;
        bad_d    = bad_q + 32'd1;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (s_axis_tlast) commit_ptr_d = wr_ptr_q + PTR_ONE;
      end
    end
  end
  always_ff @(posedge clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q      <= ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      bad_q        <= '0;
      ovf_q        <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      bad_q        <= bad_d;
      ovf_q        <= ovf_d;
      level_q      <= used;
    end
  end
  // Prefetch stage refills whenever the output register drains, giving 1 beat/clk.
  assign out_rdy = !out_vld_q || m_axis_tready;
  assign rd_en   = !empty && (!ram_vld_q || out_rdy);
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (rd_en) ram_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  end
  always_ff @(posedge clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      rd_ptr_q  <= '0;
      ram_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
      ram_vld_q <= rd_en || (ram_vld_q && !out_rdy);
      if (out_rdy) out_vld_q <= ram_vld_q;
      if (out_rdy && ram_vld_q) out_q <= ram_q;
    end
  end
  assign m_axis_tdata       = out_q[63:0];
  assign m_axis_tkeep       = out_q[71:64];
  assign m_axis_tlast       = out_q[72];
  assign m_axis_tvalid      = out_vld_q;
  assign dropped_bad_frames = bad_q;
  assign dropped_ovf_frames = ovf_q;
  assign fifo_level         = level_q;
endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb_rx_frame_fifo: randomized frame traffic against a queue-based frame model;
// a forked monitor pops expected beats whenever the DUT hands one off.
module tb_rx_frame_fifo;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  logic clk = 0, rst_n = 0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic s_tvalid = 0, s_tlast = 0, s_tuser = 0, m_tready = 0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic m_tvalid, m_tlast;
  logic [31:0] bad, ovf;
  logic [AW:0] level;
  int checks = 0, failures = 0, exp_bad = 0, exp_ovf = 0, rmode = 0;
  logic [72:0] sb[$];

  rx_frame_fifo #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .axis_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .dropped_bad_frames(bad), .dropped_ovf_frames(ovf), .fifo_level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [72:0] prev = '0, got;
    bit held = 0;
    forever begin
      @(negedge clk);
      got = {m_tlast, m_tkeep, m_tdata};
      if (!rst_n) held = 0;
      else begin
        if (held) begin
          check("hold_valid", m_tvalid, 1'b1);
          check("hold_beat", got, prev);
        end
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h required=none at %0t", got, $time);
          end else check("beat", got, sb.pop_front());
        end
        held = m_tvalid && !m_tready;
        prev = got;
      end
    end
  endtask

  // kind: 0 = frame must come out, 1 = dropped as bad, 2 = dropped as overflow
  task automatic send_frame(input int len, input bit user, input int kind);
    logic [72:0] beats[$];
    for (int i = 0; i < len; i++) begin
      logic [72:0] w;
      w[63:0]  = {$urandom, $urandom};
      w[71:64] = (i == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      w[72]    = (i == len - 1);
      s_tdata = w[63:0]; s_tkeep = w[71:64]; s_tlast = w[72];
      s_tuser = (i == len - 1) ? user : 1'($urandom);
      s_tvalid = 1;
      if (kind == 0) beats.push_back(w);
      if (i == len - 1) begin
        if (kind == 0) foreach (beats[j]) sb.push_back(beats[j]);
        else if (kind == 1) exp_bad++;
        else exp_ovf++;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 0; s_tlast = 0; s_tuser = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    rmode = 0;
    m_tready = 1;
    while ((sb.size() != 0 || m_tvalid) && n < 3000) begin @(posedge clk); n++; end
    cycles(3);
    check("drain_done", n < 3000, 1'b1);
    check("level_zero", level, '0);
    check("bad_cnt", bad, 73'(exp_bad));
    check("ovf_cnt", ovf, 73'(exp_ovf));
  endtask

  initial begin
    int n;
    fork
      monitor();
      forever begin
        @(posedge clk); #1;
        if (rmode == 1) m_tready = 1'($urandom_range(0, 1));
        else if (rmode == 2) m_tready = ~m_tready;
      end
      begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
      end
    join_none
    cycles(3);
    check("rst_valid", m_tvalid, 1'b0);
    check("rst_data", {m_tlast, m_tkeep, m_tdata}, '0);
    check("rst_level", level, '0);
    check("rst_bad", bad, '0);
    check("rst_ovf", ovf, '0);
    rst_n = 1;
    m_tready = 1;
    cycles(2);
    // latency: tvalid rises exactly two edges after the tlast edge
    send_frame(8, 0, 0);
    check("lat_e0", m_tvalid, 1'b0);
    cycles(1);
    check("lat_e1", m_tvalid, 1'b0);
    cycles(1);
    check("lat_e2", m_tvalid, 1'b1);
    drain();
    send_frame(4, 0, 0);
    send_frame(6, 1, 1);
    send_frame(3, 0, 0);
    drain();
    // oversized frame with no reads is lost; the following frame survives
    m_tready = 0;
    send_frame(DEPTH + 16, 0, 2);
    cycles(4);
    check("ovf_no_out", m_tvalid, 1'b0);
    check("ovf_rewound", level, '0);
    send_frame(5, 0, 0);
    drain();
    // exactly DEPTH words fits, with toggling backpressure on the way out
    rmode = 2;
    send_frame(DEPTH, 0, 0);
    drain();
    // level at full-1 (two words sit in the prefetch/output registers); read+write must not overflow
    m_tready = 0;
    for (int i = 0; i < 13; i++) send_frame(5, 0, 0);
    cycles(4);
    check("full_m1_level", level, 73'(DEPTH - 1));
    m_tready = 1;
    send_frame(6, 0, 0);
    drain();
    // completely full: a single-beat frame and a multi-beat bad-tuser frame both count as overflow
    m_tready = 0;
    for (int i = 0; i < 11; i++) send_frame(6, 0, 0);
    cycles(4);
    check("full_level", level, 73'(DEPTH));
    send_frame(1, 0, 2);
    send_frame(2, 1, 2);
    cycles(3);
    check("full_hold_level", level, 73'(DEPTH));
    check("full_ovf_cnt", ovf, 73'(exp_ovf));
    drain();
    // randomized traffic, admitted only when it cannot overflow
    rmode = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      bit user;
      len  = $urandom_range(1, 12);
      user = ($urandom_range(0, 3) == 0);
      n = 0;
      while (sb.size() + len > DEPTH && n < 2000) begin @(posedge clk); #1; n++; end
      send_frame(len, user, user ? 1 : 0);
      cycles($urandom_range(0, 3));
    end
    drain();
    // asynchronous reset mid-frame and mid-output
    m_tready = 0;
    send_frame(5, 0, 0);
    n = 0;
    while (!m_tvalid && n < 50) begin @(posedge clk); #1; n++; end
    check("pre_rst_valid", m_tvalid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      s_tdata = {$urandom, $urandom}; s_tkeep = 8'hFF; s_tlast = 0; s_tvalid = 1;
      @(posedge clk); #1;
    end
    #2 rst_n = 0;
    #1;
    check("arst_valid", m_tvalid, 1'b0);
    check("arst_data", {m_tlast, m_tkeep, m_tdata}, '0);
    check("arst_level", level, '0);
    s_tvalid = 0;
    sb.delete();
    exp_bad = 0;
    exp_ovf = 0;
    cycles(2);
    rst_n = 1;
    m_tready = 1;
    cycles(1);
    send_frame(4, 0, 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
